// File: rtl/drac_pkg.sv
// Shared types for the drac write-back stage: GL index and exception
// records, plus the commit-controller state encoding and retire width.
package drac_pkg;

   localparam int unsigned NUM_GL_ENTRIES = 32;
   localparam int unsigned COMMIT_WIDTH   = 2;

   typedef logic [$clog2(NUM_GL_ENTRIES)-1:0] gl_index_t;

   typedef struct packed {
      logic        valid;
      logic [5:0]  cause;
      logic [63:0] origin;
   } exception_t;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_WAIT_STORE,
      ST_WAIT_CSR,
      ST_FLUSH
   } commit_state_t;

endpackage

// File: rtl/gl_commit_ctrl_slot_sel.sv
// commit_slot_sel: picks how many of the two oldest GL entries retire
// together when the head itself is not waiting on a store/CSR/flush.
// The result is a thermometer read mask (00, 01 or 11).
module commit_slot_sel
   import drac_pkg::*;
(
   input  logic [COMMIT_WIDTH-1:0] valid_i,
   input  logic                    slot1_special_i,
   output logic [COMMIT_WIDTH-1:0] mask_o
);

   // Head retires alone unless slot1 is a plain finished entry.
   always_comb begin
      mask_o = '0;
      if (valid_i[0]) begin
         mask_o[0] = 1'b1;
         if (valid_i[1] && !slot1_special_i) begin
            mask_o[1] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/gl_commit_ctrl.sv
// gl_commit_ctrl: graduation-list consumer. Retires 0..2 head entries per
// cycle, serialises head stores and CSRs, and raises the precise-exception
// flush. Optional retired-instruction counter under `COMMIT_PERF_CNT_EN.
module gl_commit_ctrl
   import drac_pkg::*;
#(
   parameter int unsigned NUM_ENTRIES       = 32,
   parameter int unsigned STORE_ACK_TIMEOUT = 255
)(
   input  logic                             clk_i,
   input  logic                             rstn_i,
   input  logic [COMMIT_WIDTH-1:0]          instr_valid_i,
   input  logic [COMMIT_WIDTH-1:0]          instr_is_store_i,
   input  logic [COMMIT_WIDTH-1:0]          instr_is_csr_i,
   input  logic [COMMIT_WIDTH-1:0]          instr_ex_i,
   input  logic [COMMIT_WIDTH-1:0][63:0]    instr_pc_i,
   input  logic [$clog2(NUM_ENTRIES)-1:0]   gl_head_i,
   input  exception_t                       exception_i,
   input  logic [$clog2(NUM_ENTRIES)-1:0]   exception_index_i,
   input  logic                             store_ack_i,
   input  logic                             csr_done_i,
   output logic [COMMIT_WIDTH-1:0]          read_head_o,
   output logic [COMMIT_WIDTH-1:0]          commit_valid_o,
   output logic                             store_req_o,
   output logic                             csr_req_o,
   output logic                             flush_commit_o,
   output logic                             xcpt_valid_o,
   output exception_t                       xcpt_cause_o,
   output logic [63:0]                      xcpt_pc_o,
   output logic                             store_timeout_o,
   output logic [63:0]                      minstret_o
);

   localparam int unsigned TO_W = (STORE_ACK_TIMEOUT > 1) ? $clog2(STORE_ACK_TIMEOUT + 1) : 1;
   localparam logic [TO_W-1:0] TO_MAX  = TO_W'(STORE_ACK_TIMEOUT);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(STORE_ACK_TIMEOUT - 1);

   commit_state_t               state_q, state_d;
   logic [COMMIT_WIDTH-1:0]     read_head_d;
   logic                        store_req_d;
   logic                        csr_req_d;
   logic [COMMIT_WIDTH-1:0]     sel_mask;
   logic                        slot1_special;
   logic                        head_xcpt;
   logic                        flush_q;
   logic                        xcpt_valid_q;
   exception_t                  xcpt_cause_q;
   logic [63:0]                 xcpt_pc_q;
   logic [TO_W-1:0]             to_cnt_q;
   logic                        timeout_q;
   logic                        unused_pc1;

   assign unused_pc1    = ^instr_pc_i[1];
   assign slot1_special = instr_is_store_i[1] | instr_is_csr_i[1] | instr_ex_i[1];
   assign head_xcpt     = instr_ex_i[0] & exception_i.valid & (exception_index_i == gl_head_i);

   commit_slot_sel u_slot_sel (
      .valid_i         (instr_valid_i),
      .slot1_special_i (slot1_special),
      .mask_o          (sel_mask)
   );

   // Next state and the combinational handshake / read strobes.
   always_comb begin
      state_d     = state_q;
      read_head_d = '0;
      store_req_d = 1'b0;
      csr_req_d   = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            if (instr_valid_i[0]) begin
               if (head_xcpt) begin
                  state_d = ST_FLUSH;
               end else if (instr_is_store_i[0]) begin
                  store_req_d = 1'b1;
                  state_d     = ST_WAIT_STORE;
               end else if (instr_is_csr_i[0]) begin
                  csr_req_d = 1'b1;
                  state_d   = ST_WAIT_CSR;
               end else begin
                  read_head_d = sel_mask;
               end
            end
         end
         ST_WAIT_STORE: begin
            store_req_d = 1'b1;
            if (store_ack_i) begin
               read_head_d = 2'b01;
               state_d     = ST_RUN;
            end
         end
         ST_WAIT_CSR: begin
            csr_req_d = 1'b1;
            if (csr_done_i) begin
               read_head_d = 2'b01;
               state_d     = ST_RUN;
            end
         end
         ST_FLUSH: state_d = ST_RUN;
         default:  state_d = ST_RUN;
      endcase
   end

   // Combinational outputs are masked by reset so an abandoned wait drops its request at once.
   assign read_head_o    = read_head_d & {COMMIT_WIDTH{rstn_i}};
   assign commit_valid_o = read_head_o;
   assign store_req_o    = store_req_d & rstn_i;
   assign csr_req_o      = csr_req_d & rstn_i;

   // FSM state, exception report, flush pulse and store-ack watchdog.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q      <= ST_RUN;
         flush_q      <= 1'b0;
         xcpt_valid_q <= 1'b0;
         xcpt_cause_q <= '0;
         xcpt_pc_q    <= '0;
         to_cnt_q     <= '0;
         timeout_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_RUN && state_d == ST_FLUSH) begin
            flush_q      <= 1'b1;
            xcpt_valid_q <= 1'b1;
            xcpt_cause_q <= exception_i;
            xcpt_pc_q    <= instr_pc_i[0];
         end else if (state_q == ST_FLUSH) begin
            flush_q      <= 1'b0;
            xcpt_valid_q <= 1'b0;
         end
         if (state_q == ST_WAIT_STORE && !store_ack_i) begin
            if (to_cnt_q != TO_MAX) begin
               to_cnt_q <= to_cnt_q + TO_W'(1);
            end
            if (to_cnt_q >= TO_LAST) begin
               timeout_q <= 1'b1;
            end
         end else begin
            to_cnt_q <= '0;
         end
      end
   end

   assign flush_commit_o  = flush_q;
   assign xcpt_valid_o    = xcpt_valid_q;
   assign xcpt_cause_o    = xcpt_cause_q;
   assign xcpt_pc_o       = xcpt_pc_q;
   assign store_timeout_o = timeout_q;

`ifdef COMMIT_PERF_CNT_EN
   logic [63:0] minstret_q;
   logic [63:0] retire_cnt;

   // Population count of this cycle's retire pulses.
   always_comb begin
      retire_cnt = '0;
      for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
         retire_cnt = retire_cnt + 64'(commit_valid_o[k]);
      end
   end

   // Retired-instruction counter, wraps modulo 2^64.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         minstret_q <= '0;
      end else begin
         minstret_q <= minstret_q + retire_cnt;
      end
   end

   assign minstret_o = minstret_q;
`else
   assign minstret_o = '0;
`endif

endmodule

// File: tb/tb_gl_commit_ctrl.sv
// Bench for gl_commit_ctrl: directed scenarios then random traffic, all
// checked each cycle against a transaction-level model of the commit rules.
module tb_gl_commit_ctrl;
   import drac_pkg::*;

   logic              clk = 1'b0;
   logic              rstn;
   logic [1:0]        v, st, csr, ex;
   logic [1:0][63:0]  pc;
   logic [4:0]        head, xidx;
   exception_t        exc;
   logic              ack, done;
   logic [1:0]        read_head, commit_valid;
   logic              store_req, csr_req, flush, xv, tmo;
   exception_t        xcause;
   logic [63:0]       xpc, minstret;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   // model: what the commit stage is currently waiting on
   bit          m_wait_store, m_wait_csr, m_flush, m_xv, m_to;
   exception_t  m_cause;
   logic [63:0] m_pc, m_ret;
   int unsigned m_cnt;

   always #5 clk = ~clk;

   gl_commit_ctrl #(.NUM_ENTRIES(32), .STORE_ACK_TIMEOUT(255)) dut (
      .clk_i(clk), .rstn_i(rstn),
      .instr_valid_i(v), .instr_is_store_i(st), .instr_is_csr_i(csr), .instr_ex_i(ex),
      .instr_pc_i(pc), .gl_head_i(head), .exception_i(exc), .exception_index_i(xidx),
      .store_ack_i(ack), .csr_done_i(done),
      .read_head_o(read_head), .commit_valid_o(commit_valid),
      .store_req_o(store_req), .csr_req_o(csr_req), .flush_commit_o(flush),
      .xcpt_valid_o(xv), .xcpt_cause_o(xcause), .xcpt_pc_o(xpc),
      .store_timeout_o(tmo), .minstret_o(minstret)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_wait_store = 0; m_wait_csr = 0; m_flush = 0; m_xv = 0; m_to = 0;
      m_cause = '0; m_pc = '0; m_ret = '0; m_cnt = 0;
   endtask

   function automatic bit head_excepts();
      return ex[0] && exc.valid && (xidx == head);
   endfunction

   // Expected retire count and request lines for the current inputs.
   task automatic model_comb(output int unsigned n, output bit es, output bit ec);
      n = 0; es = 0; ec = 0;
      if (!rstn || m_flush) return;
      if (m_wait_store) begin
         es = 1; n = ack ? 1 : 0;
      end else if (m_wait_csr) begin
         ec = 1; n = done ? 1 : 0;
      end else if (v[0]) begin
         if (head_excepts()) n = 0;
         else if (st[0]) es = 1;
         else if (csr[0]) ec = 1;
         else if (v[1] && !(st[1] || csr[1] || ex[1])) n = 2;
         else n = 1;
      end
   endtask

   task automatic check_all();
      int unsigned n;
      bit es, ec;
      logic [1:0] mask;
      model_comb(n, es, ec);
      mask = 2'((1 << n) - 1);
      check("read_head", read_head, mask);
      check("commit_valid", commit_valid, mask);
      check("store_req", store_req, es);
      check("csr_req", csr_req, ec);
      check("flush_commit", flush, m_flush);
      check("xcpt_valid", xv, m_xv);
      check("xcpt_cause", xcause, m_cause);
      check("xcpt_pc", xpc, m_pc);
      check("store_timeout", tmo, m_to);
`ifdef COMMIT_PERF_CNT_EN
      check("minstret", minstret, m_ret);
`else
      check("minstret", minstret, 64'd0);
`endif
   endtask

   // Advance the model across one clock edge using the present inputs.
   task automatic model_update();
      int unsigned n;
      bit es, ec;
      model_comb(n, es, ec);
      m_ret = m_ret + 64'(n);
      if (m_flush) begin
         m_flush = 0; m_xv = 0;
      end else if (m_wait_store) begin
         if (ack) begin
            m_wait_store = 0; m_cnt = 0;
         end else begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt >= 255) m_to = 1;
         end
      end else if (m_wait_csr) begin
         if (done) m_wait_csr = 0;
      end else if (v[0]) begin
         if (head_excepts()) begin
            m_flush = 1; m_xv = 1; m_cause = exc; m_pc = pc[0];
         end else if (st[0]) begin
            m_wait_store = 1; m_cnt = 0;
         end else if (csr[0]) begin
            m_wait_csr = 1;
         end
      end
   endtask

   // Inputs are driven at negedge; check shortly after, then cross the posedge.
   task automatic cycle();
      #1;
      check_all();
      model_update();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_in();
      v = '0; st = '0; csr = '0; ex = '0; ack = 0; done = 0;
      exc = '0; xidx = '0; head = '0;
      pc[0] = 64'h1000; pc[1] = 64'h1004;
   endtask

   initial begin
      clear_in();
      rstn = 0;
      model_reset();
      @(negedge clk);
      // reset with a CSR presented at the head: outputs must still be idle
      csr = 2'b01; v = 2'b01;
      #1; check_all();
      @(negedge clk);
      rstn = 1;
      clear_in();

      // two plain entries retire together
      v = 2'b11; cycle();
      // slot1 store does not pair; next cycle it is the head store
      v = 2'b11; st = 2'b10; cycle();
      v = 2'b01; st = 2'b01; cycle();
      for (int i = 0; i < 3; i++) cycle();
      ack = 1; cycle();
      clear_in();

      // precise exception at head index 5
      v = 2'b01; ex = 2'b01; head = 5'd5; xidx = 5'd5;
      exc.valid = 1; exc.cause = 6'd13; exc.origin = 64'hdead;
      pc[0] = 64'h8000_0010;
      cycle();
      clear_in();
      check("flush_hi", flush, 1'b1);
      check("xcpt_pc_const", xpc, 64'h8000_0010);
      cycle();
      check("flush_one_cycle", flush, 1'b0);

      // store watchdog
      v = 2'b01; st = 2'b01; cycle();
      for (int i = 0; i < 254; i++) cycle();
      check("timeout_not_yet", tmo, 1'b0);
      cycle();
      check("timeout_set", tmo, 1'b1);
      for (int i = 0; i < 5; i++) cycle();
      ack = 1; cycle();
      ack = 0; st = 2'b00; v = 2'b00; cycle();
      check("timeout_sticky", tmo, 1'b1);

      // CSR serialisation; stray acks in RUN do nothing
      v = 2'b11; ack = 1; done = 1; cycle();
      ack = 0; done = 0;
      v = 2'b01; csr = 2'b01; cycle();
      for (int i = 0; i < 4; i++) cycle();
      done = 1; cycle();
      clear_in();

      // random traffic
      for (int i = 0; i < 600; i++) begin
         v    = 2'($urandom_range(0, 3));
         st   = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
         csr  = {($urandom_range(0, 6) == 0), ($urandom_range(0, 6) == 0)};
         ex   = {($urandom_range(0, 6) == 0), ($urandom_range(0, 4) == 0)};
         head = 5'($urandom);
         xidx = ($urandom_range(0, 1) == 0) ? head : 5'($urandom);
         exc.valid  = $urandom_range(0, 1) == 0;
         exc.cause  = 6'($urandom);
         exc.origin = {$urandom, $urandom};
         pc[0] = {$urandom, $urandom};
         pc[1] = {$urandom, $urandom};
         ack  = $urandom_range(0, 2) == 0;
         done = $urandom_range(0, 2) == 0;
         cycle();
      end
      clear_in();

      // asynchronous reset while waiting on a CSR
      v = 2'b01; csr = 2'b01; cycle();
      cycle();
      rstn = 0;
      model_reset();
      #1; check_all();
      check("csr_req_reset", csr_req, 1'b0);
      @(negedge clk);
      rstn = 1;
      clear_in();
      cycle();
      check("minstret_after_reset", minstret, 64'd0);
      v = 2'b11; cycle();
      v = 2'b01; cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
